avalon_st_channel_adapter: RTL
==============================

Name: avalon_st_channel_adapter

Overview:
- Parametrised Avalon-ST channel adapter with an optional registered output stage (skid buffer).
- Sits between a packet source, such as the byte-stream master path to DDR3, and a channelised sink.
- Maps the input channel to the output channel width, locks the channel for the whole packet, and drops out-of-range packets with a saturating drop counter.
- Replaces the fixed 8-bit, zero-channel pass-through adapters.

Parameters:
- DATA_W, 8, payload width in bits.
- IN_CHANNEL_W, 4, input channel width (>=1).
- OUT_CHANNEL_W, 8, output channel width (>=1).
- MAX_CHANNEL, 255, highest legal channel. Packets with a larger SOP channel are dropped. Must be <= 2**OUT_CHANNEL_W-1.
- PIPELINE, 1, 0 = combinational data path, 1 = registered 2-entry skid buffer on the output.

Ports:
- clk  input  1  sole clock
- reset_n  input  1  asynchronous active-low reset
- in_ready  output  1  sink-ready to upstream
- in_valid  input  1  input beat valid
- in_data  input  DATA_W  input payload
- in_channel  input  IN_CHANNEL_W  channel, sampled only on the SOP beat
- in_startofpacket  input  1  start of packet
- in_endofpacket  input  1  end of packet
- out_ready  input  1  downstream ready
- out_valid  output  1  output beat valid
- out_data  output  DATA_W  output payload
- out_startofpacket  output  1  start of packet
- out_endofpacket  output  1  end of packet
- out_channel  output  OUT_CHANNEL_W  locked channel, zero-extended
- drop_count  output  16  packets dropped, saturating

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset values: out_valid=0, out_data=0, out_startofpacket=0, out_endofpacket=0, out_channel=0, drop_count=0, state=IDLE, skid buffer empty.
  - in_ready=0 while reset_n=0.
  - Reset mid-packet discards all buffered beats and the locked channel.
- Handshake: a beat transfers when valid && ready.
  - ready-latency 0 on both sides.
  - While out_valid=1 and out_ready=0, all out_* hold stable.
- Packet state machine, advancing only on accepted input beats:
  - IDLE:
    - SOP beat with in_channel <= MAX_CHANNEL: lock the channel, forward the beat. Next state is PASS, or IDLE if EOP is also set.
    - SOP beat with in_channel > MAX_CHANNEL: discard the beat, drop_count += 1. Next state is DROP, or IDLE if EOP is also set.
    - Non-SOP beat (orphan): discarded silently, state stays IDLE, not counted.
  - PASS:
    - Each beat is forwarded with the locked channel; in_channel is ignored.
    - EOP beat: forward, then IDLE.
    - SOP beat while in PASS (missing EOP): treated as a new packet with the IDLE rules. The prior packet is not closed by the adapter.
  - DROP:
    - in_ready=1 unconditionally, independent of out_ready and buffer fill.
    - Beats are discarded.
    - EOP beat: IDLE.
    - SOP beat: re-evaluated with the IDLE rules.
- Channel width: out_channel = zero-extended locked channel. If IN_CHANNEL_W > OUT_CHANNEL_W, the range check runs on the full input value before truncation, so no aliasing occurs.
- drop_count saturates at 16'hFFFF and never wraps.
- PIPELINE=0:
  - out_valid = in_valid && the beat would be forwarded.
  - out_* are combinational from the inputs plus the locked channel.
  - Outside DROP and orphan cases, in_ready = out_ready. For orphan beats in IDLE, in_ready=1.
- PIPELINE=1:
  - 2-entry skid buffer; in_ready is a registered !full.
  - Latency 1 cycle from input accept to out_valid.
  - Full throughput of 1 beat per cycle under continuous out_ready=1.
  - If out_ready deasserts, at most one extra beat is captured in the skid entry, and in_ready drops the following cycle.
  - On out_ready reassertion, the skid entry drains first, preserving order.
- Simultaneous push and pop on a full buffer: allowed, and occupancy stays unchanged.
- No beat is duplicated, reordered or lost except drops and orphans.

Test Plan:
- PIPELINE=1, out_ready=1. Send a 4-beat packet with data 0x11,0x22,0x33,0x44 and SOP channel 3; in_channel changes to 7 on beat 2.
  - Required: out beats appear 1 cycle after each accept, all with out_channel=8'h03.
  - Required: SOP on 0x11, EOP on 0x44, drop_count=0.
- MAX_CHANNEL=5. Send a 3-beat packet on channel 9 with out_ready=0.
  - Required: in_ready=1 for all 3 beats, no out_valid, drop_count=1, state IDLE after EOP.
  - Then send a channel-2 packet. Required: forwarded normally.
- Backpressure: stream 8 beats while toggling out_ready as 1,0,0,1,0,1,1,1.
  - Required: the output sequence equals the input sequence, out_* stable while stalled, and in_ready low no earlier than 1 cycle after the first stall.
- Orphan beat 0xAA without SOP in IDLE.
  - Required: discarded, drop_count unchanged.
  - Then a single-beat SOP+EOP packet 0xBB on channel 1. Required: one output beat with out_channel=1, SOP=EOP=1.
- Drop 65,537 out-of-range single-beat packets.
  - Required: drop_count=16'hFFFF, no wrap.
- Assert reset_n=0 mid-packet with 2 beats buffered.
  - Required: outputs go to reset values immediately, buffered beats are lost, and a fresh SOP packet after release is forwarded correctly.
  - Repeat the first scenario with PIPELINE=0. Required: latency 0.

Source files
------------

// File: rtl/avalon_st_channel_adapter.sv
// Avalon-ST channel adapter.
// Widens or narrows the channel field, locks the channel from the SOP beat for
// the rest of the packet, drops packets whose SOP channel is out of range
// (counting them in a saturating counter) and silently discards orphan beats.
// The output is either combinational (PIPELINE=0) or a 2-entry skid buffer
// (PIPELINE=1) whose in_ready comes straight from the occupancy register.
module avalon_st_channel_adapter #(
    parameter int DATA_W        = 8,
    parameter int IN_CHANNEL_W  = 4,
    parameter int OUT_CHANNEL_W = 8,
    parameter int MAX_CHANNEL   = 255,
    parameter int PIPELINE      = 1
) (
    input  logic                     clk,
    input  logic                     reset_n,
    output logic                     in_ready,
    input  logic                     in_valid,
    input  logic [DATA_W-1:0]        in_data,
    input  logic [IN_CHANNEL_W-1:0]  in_channel,
    input  logic                     in_startofpacket,
    input  logic                     in_endofpacket,
    input  logic                     out_ready,
    output logic                     out_valid,
    output logic [DATA_W-1:0]        out_data,
    output logic                     out_startofpacket,
    output logic                     out_endofpacket,
    output logic [OUT_CHANNEL_W-1:0] out_channel,
    output logic [15:0]              drop_count
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_PASS = 2'd1;
    localparam logic [1:0] ST_DROP = 2'd2;

    // Range check is done at a width that holds the full input channel, the
    // output channel and MAX_CHANNEL, so a wide input can never alias into
    // the legal range by truncation.
    localparam int CMP_W0 = (IN_CHANNEL_W > OUT_CHANNEL_W) ? IN_CHANNEL_W : OUT_CHANNEL_W;
    localparam int CMP_W  = (CMP_W0 > 32) ? CMP_W0 : 32;
    localparam logic [CMP_W-1:0] MAX_CH_EXT = CMP_W'(MAX_CHANNEL);

    // One queue entry: {sop, eop, channel, data}
    localparam int ENT_W = DATA_W + OUT_CHANNEL_W + 2;

    logic [1:0]               state;
    logic [OUT_CHANNEL_W-1:0] lock_ch;
    logic [CMP_W-1:0]         ch_ext;
    logic                     in_range;
    logic                     fwd;
    logic                     accept;
    logic                     push;
    logic                     path_ready;
    logic [OUT_CHANNEL_W-1:0] beat_ch;
    logic [ENT_W-1:0]         push_ent;
    logic [ENT_W-1:0]         head_ent;

    assign ch_ext   = CMP_W'(in_channel);
    assign in_range = (ch_ext <= MAX_CH_EXT);

    // An SOP always starts a new packet (even mid-PASS or mid-DROP) and is
    // forwarded only if its channel is legal; non-SOP beats ride along only
    // while a legal packet is open.  Everything else is discarded.
    assign fwd     = in_startofpacket ? in_range : (state == ST_PASS);
    assign beat_ch = in_startofpacket ? ch_ext[OUT_CHANNEL_W-1:0] : lock_ch;

    // Discarded beats never wait on the output path, so DROP and orphan
    // beats are always swallowed immediately.
    assign in_ready = reset_n && (!fwd || path_ready);
    assign accept   = in_valid && in_ready;
    assign push     = accept && fwd;
    assign push_ent = {in_startofpacket, in_endofpacket, beat_ch, in_data};

    // Packet state machine and channel lock, advancing on accepted beats only
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= ST_IDLE;
            lock_ch <= '0;
        end else if (accept) begin
            if (in_startofpacket) begin
                if (in_range) begin
                    lock_ch <= beat_ch;
                end
                if (in_endofpacket) begin
                    state <= ST_IDLE;
                end else begin
                    state <= in_range ? ST_PASS : ST_DROP;
                end
            end else if (in_endofpacket) begin
                // Orphan EOP in IDLE lands here too, harmlessly.
                state <= ST_IDLE;
            end
        end
    end

    // Saturating count of packets dropped for an out-of-range SOP channel
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            drop_count <= '0;
        end else if (accept && in_startofpacket && !in_range && (drop_count != 16'hFFFF)) begin
            drop_count <= drop_count + 16'd1;
        end
    end

    generate
        if (PIPELINE != 0) begin : g_skid
            // Two-entry circular buffer; the head entry drives out_* directly
            // from flops, and in_ready depends only on occupancy so the input
            // side never sees a combinational path from out_ready.
            logic [ENT_W-1:0] mem [2];
            logic             rd_ptr;
            logic             wr_ptr;
            logic [1:0]       count;
            logic             pop;

            assign pop        = out_valid && out_ready;
            assign path_ready = (count != 2'd2);
            assign out_valid  = (count != 2'd0);
            assign head_ent   = mem[rd_ptr];

            // Buffer storage, pointers and occupancy; push and pop may coincide
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    mem[0] <= '0;
                    mem[1] <= '0;
                    rd_ptr <= 1'b0;
                    wr_ptr <= 1'b0;
                    count  <= 2'd0;
                end else begin
                    if (push) begin
                        mem[wr_ptr] <= push_ent;
                        wr_ptr      <= !wr_ptr;
                    end
                    if (pop) begin
                        rd_ptr <= !rd_ptr;
                    end
                    count <= count + {1'b0, push} - {1'b0, pop};
                end
            end
        end else begin : g_comb
            // Straight-through path; held at reset values while in reset.
            assign path_ready = out_ready;
            assign out_valid  = reset_n && in_valid && fwd;
            assign head_ent   = reset_n ? push_ent : '0;
        end
    endgenerate

    assign {out_startofpacket, out_endofpacket, out_channel, out_data} = head_ent;

endmodule
